// File: rtl/execute_divide.sv
// execute_divide: iterative radix-2 restoring divider for x86 DIV/IDIV
// in 8-, 16- and 32-bit forms. It produces one quotient bit per cycle and
// works on magnitudes throughout; signs are applied in a final fix-up cycle.
module execute_divide (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_reset,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [1:0]  div_size,
  input  logic [63:0] div_dividend,
  input  logic [31:0] div_divisor,
  output logic        div_busy,
  output logic        exe_div_exception,
  output logic [31:0] div_result_quotient,
  output logic [31:0] div_result_remainder
);

  typedef enum logic [1:0] {IDLE, CHECK, DIVIDE, FIX} state_t;

  state_t      state, state_next;
  logic [31:0] rem_q, low_q, dvs_q;
  logic [5:0]  count_q;
  logic        qneg_q, rneg_q, signed_q;
  logic [1:0]  size_q;

  logic        in_dvd_neg, in_dvs_neg;
  logic [63:0] in_dvd_ext, in_dvd_mag;
  logic [31:0] in_dvs_ext, in_dvs_mag, in_hi, in_lo;

  logic        check_fail, take_bit, overflow;
  logic [32:0] trial;
  logic [31:0] diff, fix_mask, half, q_out, r_out;
  logic [5:0]  n_bits;

  // Low-N-bit mask for an operand size; size 3 behaves as 32-bit
  function automatic logic [31:0] size_mask(input logic [1:0] s);
    case (s)
      2'd0:    size_mask = 32'h0000_00FF;
      2'd1:    size_mask = 32'h0000_FFFF;
      default: size_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  // Operand preparation from the raw inputs: sign-extend, take magnitudes,
  // and split the dividend magnitude into a high half and a left-aligned low half
  always_comb begin
    in_dvd_neg = 1'b0;
    in_dvs_neg = 1'b0;
    in_dvd_ext = '0;
    in_dvs_ext = '0;
    case (div_size)
      2'd0: begin
        in_dvd_neg = div_signed & div_dividend[15];
        in_dvs_neg = div_signed & div_divisor[7];
        in_dvd_ext = {{48{in_dvd_neg}}, div_dividend[15:0]};
        in_dvs_ext = {{24{in_dvs_neg}}, div_divisor[7:0]};
      end
      2'd1: begin
        in_dvd_neg = div_signed & div_dividend[47];
        in_dvs_neg = div_signed & div_divisor[15];
        in_dvd_ext = {{32{in_dvd_neg}}, div_dividend[47:32], div_dividend[15:0]};
        in_dvs_ext = {{16{in_dvs_neg}}, div_divisor[15:0]};
      end
      default: begin
        in_dvd_neg = div_signed & div_dividend[63];
        in_dvs_neg = div_signed & div_divisor[31];
        in_dvd_ext = div_dividend;
        in_dvs_ext = div_divisor;
      end
    endcase
    in_dvd_mag = in_dvd_neg ? (~in_dvd_ext + 64'd1) : in_dvd_ext;
    in_dvs_mag = (in_dvs_neg ? (~in_dvs_ext + 32'd1) : in_dvs_ext) & size_mask(div_size);
    case (div_size)
      2'd0: begin
        in_hi = {24'd0, in_dvd_mag[15:8]};
        in_lo = {in_dvd_mag[7:0], 24'd0};
      end
      2'd1: begin
        in_hi = {16'd0, in_dvd_mag[31:16]};
        in_lo = {in_dvd_mag[15:0], 16'd0};
      end
      default: begin
        in_hi = in_dvd_mag[63:32];
        in_lo = in_dvd_mag[31:0];
      end
    endcase
  end

  // Datapath for the latched operation: range check, trial subtract and sign fix-up
  always_comb begin
    case (size_q)
      2'd0:    begin n_bits = 6'd8;  half = 32'h0000_0080; end
      2'd1:    begin n_bits = 6'd16; half = 32'h0000_8000; end
      default: begin n_bits = 6'd32; half = 32'h8000_0000; end
    endcase
    fix_mask   = size_mask(size_q);
    check_fail = (dvs_q == 32'd0) || (rem_q >= dvs_q);
    trial      = {rem_q, low_q[31]};
    take_bit   = trial >= {1'b0, dvs_q};
    diff       = trial[31:0] - dvs_q;
    q_out      = (qneg_q ? (~low_q + 32'd1) : low_q) & fix_mask;
    r_out      = (rneg_q ? (~rem_q + 32'd1) : rem_q) & fix_mask;
    overflow   = signed_q && (qneg_q ? (low_q > half) : (low_q > (half - 32'd1)));
  end

  // Next-state logic; a flush always wins and returns the FSM to IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (div_start) state_next = CHECK;
      CHECK:   state_next = check_fail ? IDLE : DIVIDE;
      DIVIDE:  if (count_q == 6'd1) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (exe_reset) state_next = IDLE;
  end

  // State, operand and result registers; a flush clears only state and exception
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      div_busy             <= 1'b0;
      exe_div_exception    <= 1'b0;
      div_result_quotient  <= '0;
      div_result_remainder <= '0;
      rem_q                <= '0;
      low_q                <= '0;
      dvs_q                <= '0;
      count_q              <= '0;
      qneg_q               <= 1'b0;
      rneg_q               <= 1'b0;
      signed_q             <= 1'b0;
      size_q               <= 2'd0;
    end else begin
      state    <= state_next;
      div_busy <= (state_next != IDLE);
      if (exe_reset) begin
        exe_div_exception <= 1'b0;
      end else begin
        case (state)
          IDLE: if (div_start) begin
            rem_q             <= in_hi;
            low_q             <= in_lo;
            dvs_q             <= in_dvs_mag;
            qneg_q            <= in_dvd_neg ^ in_dvs_neg;
            rneg_q            <= in_dvd_neg;
            signed_q          <= div_signed;
            size_q            <= div_size;
            exe_div_exception <= 1'b0;
          end
          CHECK: begin
            if (check_fail) exe_div_exception <= 1'b1;
            else            count_q <= n_bits;
          end
          DIVIDE: begin
            rem_q   <= take_bit ? diff : trial[31:0];
            low_q   <= {low_q[30:0], take_bit};
            count_q <= count_q - 6'd1;
          end
          FIX: begin
            if (overflow) begin
              exe_div_exception <= 1'b1;
            end else begin
              div_result_quotient  <= q_out;
              div_result_remainder <= r_out;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_execute_divide.sv
// tb_execute_divide: directed and random DIV/IDIV operations checked against
// an arithmetic reference model through a scoreboard queue.
module tb_execute_divide;

  logic        clk;
  logic        rst;
  logic        exe_reset;
  logic        div_start;
  logic        div_signed;
  logic [1:0]  div_size;
  logic [63:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_busy;
  logic        exe_div_exception;
  logic [31:0] div_result_quotient;
  logic [31:0] div_result_remainder;

  typedef struct {
    string       tag;
    logic        exc;
    logic [31:0] q;
    logic [31:0] r;
    int          busy;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          hold_cycles = 1;
  logic [31:0] prev_q = '0;
  logic [31:0] prev_r = '0;

  execute_divide dut (
    .clk                  (clk),
    .rst                  (rst),
    .exe_reset            (exe_reset),
    .div_start            (div_start),
    .div_signed           (div_signed),
    .div_size             (div_size),
    .div_dividend         (div_dividend),
    .div_divisor          (div_divisor),
    .div_busy             (div_busy),
    .exe_div_exception    (exe_div_exception),
    .div_result_quotient  (div_result_quotient),
    .div_result_remainder (div_result_remainder)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain wide division on magnitudes, x86 sign rules
  function automatic exp_t model(input string tag, input logic sgn, input logic [1:0] sz,
                                 input logic [63:0] dvd, input logic [31:0] dvs);
    exp_t        e;
    int          n;
    logic [63:0] nmask, dmask, d_val, v_val, dm, vm, qm, rm, half;
    logic        dn, vn, qn;
    n     = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
    nmask = (64'd1 << n) - 64'd1;
    dmask = (n == 32) ? '1 : ((64'd1 << (2 * n)) - 64'd1);
    half  = 64'd1 << (n - 1);
    case (sz)
      2'd0:    d_val = {48'd0, dvd[15:0]};
      2'd1:    d_val = {32'd0, dvd[47:32], dvd[15:0]};
      default: d_val = dvd;
    endcase
    v_val = {32'd0, dvs} & nmask;
    dn = sgn && d_val[2 * n - 1];
    vn = sgn && v_val[n - 1];
    qn = dn ^ vn;
    dm = dn ? ((~d_val + 64'd1) & dmask) : d_val;
    vm = vn ? ((~v_val + 64'd1) & nmask) : v_val;
    e.tag = tag;
    e.q   = prev_q;
    e.r   = prev_r;
    if (vm == 64'd0) begin
      e.exc  = 1'b1;
      e.busy = 1;
      return e;
    end
    qm = dm / vm;
    rm = dm % vm;
    if (qm > nmask) begin
      e.exc  = 1'b1;
      e.busy = 1;
      return e;
    end
    e.busy = n + 2;
    if (sgn && (qn ? (qm > half) : (qm > half - 64'd1))) begin
      e.exc = 1'b1;
      return e;
    end
    e.exc = 1'b0;
    e.q   = 32'((qn ? (~qm + 64'd1) : qm) & nmask);
    e.r   = 32'((dn ? (~rm + 64'd1) : rm) & nmask);
    return e;
  endfunction

  // Drive one start request at a falling edge and record its expected outcome
  task automatic apply_stimulus(input string tag, input logic sgn, input logic [1:0] sz,
                                input logic [63:0] dvd, input logic [31:0] dvs, input int hold);
    exp_t e;
    e = model(tag, sgn, sz, dvd, dvs);
    if (!e.exc) begin
      prev_q = e.q;
      prev_r = e.r;
    end
    sb.push_back(e);
    hold_cycles  = hold;
    div_signed   = sgn;
    div_size     = sz;
    div_dividend = dvd;
    div_divisor  = dvs;
    div_start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Count busy cycles, then compare exception and results with the scoreboard head
  task automatic check_output();
    exp_t e;
    int   cnt;
    e   = sb.pop_front();
    cnt = 0;
    while (div_busy === 1'b1 && cnt < 200) begin
      if (cnt >= hold_cycles - 1) div_start = 1'b0;
      cnt++;
      @(negedge clk);
    end
    div_start = 1'b0;
    checks++;
    assert (cnt < 200) else begin
      errors++;
      $error("[TB] FAIL %s timeout: busy still high after %0d cycles, required low", e.tag, cnt);
    end
    checks++;
    assert (cnt === e.busy) else begin
      errors++;
      $error("[TB] FAIL %s busy_cycles: got %0d expected %0d", e.tag, cnt, e.busy);
    end
    checks++;
    assert (exe_div_exception === e.exc) else begin
      errors++;
      $error("[TB] FAIL %s exception: got %b expected %b", e.tag, exe_div_exception, e.exc);
    end
    checks++;
    assert (div_result_quotient === e.q) else begin
      errors++;
      $error("[TB] FAIL %s quotient: got %h expected %h", e.tag, div_result_quotient, e.q);
    end
    checks++;
    assert (div_result_remainder === e.r) else begin
      errors++;
      $error("[TB] FAIL %s remainder: got %h expected %h", e.tag, div_result_remainder, e.r);
    end
  endtask

  // Directed sequence followed by a short random sweep
  initial begin
    exp_t e;
    rst          = 1'b1;
    exe_reset    = 1'b0;
    div_start    = 1'b0;
    div_signed   = 1'b0;
    div_size     = 2'd0;
    div_dividend = '0;
    div_divisor  = '0;
    repeat (3) @(negedge clk);

    checks++;
    assert ({div_busy, exe_div_exception} === 2'b00) else begin
      errors++;
      $error("[TB] FAIL reset_flags: got %b expected 00", {div_busy, exe_div_exception});
    end
    checks++;
    assert ({div_result_quotient, div_result_remainder} === 64'd0) else begin
      errors++;
      $error("[TB] FAIL reset_results: got %h expected 0", {div_result_quotient, div_result_remainder});
    end
    rst = 1'b0;
    @(negedge clk);

    apply_stimulus("div8_100_7", 1'b0, 2'd0, 64'h0064, 32'h07, 1);
    check_output();
    apply_stimulus("idiv32_m7_2", 1'b1, 2'd2, 64'hFFFF_FFFF_FFFF_FFF9, 32'd2, 1);
    check_output();
    apply_stimulus("div16_by_zero", 1'b0, 2'd1, 64'h0000_0000_0000_1234, 32'd0, 1);
    check_output();
    apply_stimulus("div16_hi_ge", 1'b0, 2'd1, 64'h0000_0001_0000_0000, 32'd1, 1);
    check_output();
    apply_stimulus("idiv8_p128_1", 1'b1, 2'd0, 64'h0080, 32'h01, 1);
    check_output();
    apply_stimulus("idiv8_m128_m1", 1'b1, 2'd0, 64'hFF80, 32'hFF, 1);
    check_output();
    apply_stimulus("idiv8_m128_1", 1'b1, 2'd0, 64'hFF80, 32'h01, 1);
    check_output();
    apply_stimulus("div16_start_held", 1'b0, 2'd1, 64'h0000_0003_0000_1234, 32'h1000, 4);
    check_output();
    apply_stimulus("idiv16_neg_div", 1'b1, 2'd1, 64'h0000_0000_0000_03E8, 32'hFFF9, 1);
    check_output();
    apply_stimulus("div_size3", 1'b0, 2'd3, 64'h0000_0005_0000_0007, 32'h0000_0010, 1);
    check_output();

    // Flush during the fifth DIVIDE cycle of a 32-bit divide
    div_signed   = 1'b0;
    div_size     = 2'd2;
    div_dividend = 64'h0000_0000_DEAD_BEEF;
    div_divisor  = 32'h0000_1234;
    div_start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    exe_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exe_reset = 1'b0;
    checks++;
    assert ({div_busy, exe_div_exception} === 2'b00) else begin
      errors++;
      $error("[TB] FAIL flush_flags: got %b expected 00", {div_busy, exe_div_exception});
    end
    checks++;
    assert ({div_result_quotient, div_result_remainder} === {prev_q, prev_r}) else begin
      errors++;
      $error("[TB] FAIL flush_results: got %h expected %h",
             {div_result_quotient, div_result_remainder}, {prev_q, prev_r});
    end
    apply_stimulus("div32_after_flush", 1'b0, 2'd2, 64'h0000_0000_DEAD_BEEF, 32'h0000_1234, 1);
    check_output();

    for (int i = 0; i < 8; i++) begin
      logic [1:0]  sz;
      logic [63:0] dvd;
      logic [31:0] dvs;
      sz  = 2'(i % 3);
      dvd = {16'd0, 16'($urandom_range(0, 3)), $urandom};
      dvs = $urandom | 32'h0000_0101;
      apply_stimulus($sformatf("random_%0d", i), 1'(i & 1), sz, dvd, dvs, 1);
      check_output();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
